multdiv_ctrl: RTL
=================

# multdiv_ctrl

Sequencer for the iterative multiply/divide datapath. It accepts single-cycle start pulses from the execute stage and produces load and step enables for the datapath's negative-edge enable flops. It runs a fixed-length iteration count, then signals completion or divide-by-zero. It also drives the pipeline stall for the whole operation. All outputs are registered-state (Moore) decodes on the rising edge, so the negative-edge datapath flops sample them half a cycle after they settle.

## Interface
- MULT_CYCLES, 32: number of RUN iterations for a multiply (2..63)
- DIV_CYCLES, 32: number of RUN iterations for a divide (2..63)
- clk  in  1  clock; all state updates on rising edge
- clr  in  1  synchronous, active-high reset
- ctrl_MULT  in  1  start-multiply pulse
- ctrl_DIV  in  1  start-divide pulse
- divisor_zero  in  1  datapath flag: loaded divisor == 0; sampled only in LOAD
- en_load  out  1  load operand/partial registers
- en_step  out  1  advance one iteration in datapath registers
- sel_op  out  1  0 = multiply, 1 = divide
- count  out  6  current iteration index
- busy  out  1  pipeline stall request
- data_resultRDY  out  1  result valid, one-cycle pulse
- data_exception  out  1  divide-by-zero, valid with data_resultRDY

## Operation
- States: IDLE, LOAD, RUN, DONE. Reset (clr=1 at a rising edge) forces IDLE regardless of any other input. Reset values: count=0, sel_op=0, and all other outputs 0.
- Start pulses:
  - A start is ctrl_MULT or ctrl_DIV high at a rising edge, in any state.
  - A start moves to LOAD, sets count=0, and latches sel_op (DIV → 1, MULT → 0).
  - If both are high, MULT wins.
  - A start in LOAD, RUN or DONE aborts the current operation and restarts. The aborted operation raises no data_resultRDY.
- LOAD: en_load=1 and busy=1.
  - If sel_op=1 and divisor_zero=1: go to DONE with the exception flag set.
  - Otherwise: go to RUN with count=0.
- RUN: en_step=1 and busy=1.
  - count increments by 1 each cycle.
  - When count == N-1 (N = MULT_CYCLES or DIV_CYCLES per sel_op), go to DONE. count holds N-1.
- DONE: data_resultRDY=1 and busy=0; data_exception equals the flag set in LOAD. Go to IDLE next cycle. The exception flag clears on leaving DONE.
- IDLE: all enables 0. count and sel_op hold their last values.
- count is 6-bit unsigned and never wraps within an operation.
- en_load, en_step and data_resultRDY are mutually exclusive.
- divisor_zero is ignored outside LOAD and for multiplies.

## Timing
- Cycle 0 is the cycle in which the start pulse is sampled.
- Normal operation:
  - Cycle 1: LOAD.
  - Cycles 2..N+1: RUN, count = 0..N-1.
  - Cycle N+2: DONE.
  - Total start-to-ready latency is N+2 cycles: 34 for the 32/32 defaults.
- Divide by zero: cycle 1 LOAD, cycle 2 DONE with data_resultRDY=1 and data_exception=1. Latency is 2 cycles.
- busy is high in cycles 1..N+1 and low in DONE. The pipeline captures the result in the DONE cycle.
- A start in the DONE cycle gives LOAD on the next cycle with no IDLE cycle between. The current result is still flagged in DONE.
- clr mid-operation: IDLE at the next edge; no resultRDY; enables drop in the same edge.
- Datapath flops capture en_load/en_step on the falling edge within the same cycle. Decode logic must leave no combinational path from inputs to these outputs.

## Test plan
- Reset: assert clr 2 cycles during RUN (count=10) → next edge: IDLE, count=0, sel_op=0, all outputs 0, no resultRDY.
- Multiply: ctrl_MULT in cycle 0 → en_load in cycle 1 only; en_step in cycles 2..33 with count 0..31; data_resultRDY=1 and data_exception=0 in cycle 34 only; busy high cycles 1..33.
- Divide by zero: ctrl_DIV with divisor_zero=1 in LOAD → data_resultRDY=1 and data_exception=1 in cycle 2; en_step never asserted; busy high in cycle 1 only.
- Divide with divisor_zero=1 during RUN only → no exception; resultRDY in cycle 34 with data_exception=0.
- Restart: ctrl_DIV at count=5 of a multiply → LOAD next cycle, sel_op=1, count=0; exactly one resultRDY, 34 cycles after the ctrl_DIV pulse.
- Simultaneous: ctrl_MULT and ctrl_DIV in the same cycle → sel_op=0, MULT_CYCLES iterations; back-to-back start in the DONE cycle → resultRDY still pulses, LOAD follows immediately.

Source files
------------

// File: rtl/multdiv_ctrl.sv
// Sequencer for the iterative multiply/divide datapath: LOAD, N RUN steps, DONE.
// Latency: start-to-result N+2 cycles (2 cycles on divide-by-zero); outputs are state decodes.
// Backpressure: none; busy stalls the pipeline and any new start aborts and restarts.
module multdiv_ctrl #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ctrl_MULT,
  input  logic       ctrl_DIV,
  input  logic       divisor_zero,
  output logic       en_load,
  output logic       en_step,
  output logic       sel_op,
  output logic [5:0] count,
  output logic       busy,
  output logic       data_resultRDY,
  output logic       data_exception
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Index of the final RUN iteration for each operation.
  localparam logic [5:0] MULT_LAST = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LAST  = 6'(DIV_CYCLES - 1);

  state_t     state_q, state_d;
  logic [5:0] count_q, count_d;
  logic       sel_op_q, sel_op_d;
  logic       exc_q, exc_d;

  logic       start;
  logic [5:0] last_idx;

  assign start    = ctrl_MULT | ctrl_DIV;
  assign last_idx = sel_op_q ? DIV_LAST : MULT_LAST;

  // State, iteration counter, operation select and exception flag registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      count_q  <= 6'd0;
      sel_op_q <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      sel_op_q <= sel_op_d;
      exc_q    <= exc_d;
    end
  end

  // Next-state logic; a start in any state restarts from LOAD, MULT beating DIV.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    sel_op_d = sel_op_q;
    exc_d    = exc_q;
    if (start) begin
      state_d  = LOAD;
      count_d  = 6'd0;
      sel_op_d = ~ctrl_MULT;
      exc_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        LOAD: begin
          // divisor_zero is only meaningful once the divisor has been loaded.
          if (sel_op_q && divisor_zero) begin
            state_d = DONE;
            exc_d   = 1'b1;
          end else begin
            state_d = RUN;
            count_d = 6'd0;
          end
        end
        RUN: begin
          // count stops at the last index so it never wraps.
          if (count_q == last_idx) begin
            state_d = DONE;
          end else begin
            count_d = count_q + 6'd1;
          end
        end
        DONE: begin
          state_d = IDLE;
          exc_d   = 1'b0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Moore output decode: purely from registered state so the negedge flops see settled values.
  always_comb begin
    en_load        = (state_q == LOAD);
    en_step        = (state_q == RUN);
    busy           = (state_q == LOAD) || (state_q == RUN);
    data_resultRDY = (state_q == DONE);
    data_exception = (state_q == DONE) && exc_q;
    sel_op         = sel_op_q;
    count          = count_q;
  end

endmodule
